// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared declarations for the NoC router output stage:
//   arb_state_e  - per-VC input arbiter state (IDLE / LOCKED)
//   idx_w()      - width of an index able to address n items (at least 1 bit)
//   wrap_inc()   - increment an index modulo n (n need not be a power of two)
// -----------------------------------------------------------------------------
package noc_pkg;

  // An input arbiter is either free to pick a new packet or held by one
  // input until that packet's last flit has been accepted.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Index width for n items; a single item still needs a 1-bit index so
  // that ports and registers never collapse to zero width.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // (idx + 1) mod n without relying on n being a power of two.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage : noc_pkg

// File: rtl/noc_router_arb_rr.sv
// -----------------------------------------------------------------------------
// noc_router_arb_rr
// Purely combinational round-robin picker: grants the first requester at or
// after ptr, wrapping around. Holds no state; the caller owns the pointer.
//
// Parameters:
//   N          number of requesters
// Ports:
//   req        [N-1:0]         request vector
//   ptr        [idx_w(N)-1:0]  highest-priority index (must be < N)
//   grant      [N-1:0]         one-hot grant, all zero when nothing requests
//   grant_idx  [idx_w(N)-1:0]  binary index of the grant (0 when none)
// -----------------------------------------------------------------------------
module noc_router_arb_rr
  import noc_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]        req,
  input  logic [idx_w(N)-1:0] ptr,
  output logic [N-1:0]        grant,
  output logic [idx_w(N)-1:0] grant_idx
);

  localparam int W = idx_w(N);

  always_comb begin
    int  idx;
    logic found;
    // NOTE: every output gets a default before the search loop; without it a
    // cycle with no request would leave them unassigned and infer latches.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      // ptr < N, so a single subtraction is enough to wrap.
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = W'(idx);
      end
    end
  end

endmodule : noc_router_arb_rr

// File: rtl/noc_router_output.sv
// -----------------------------------------------------------------------------
// noc_router_output
// One output port of a NoC router. For every virtual channel, the router
// inputs compete through a packet-locking round-robin arbiter; the winner's
// flits go into a per-VC FIFO. A second round-robin arbiter then picks one
// VC per cycle to drive the link.
//
// Optional feature (macro NOC_ROUTER_OUTPUT_VCLOCK_EN):
//   defined   - the VC arbiter stays on a VC from its first non-last transfer
//               until that VC's last flit leaves, so packets never interleave
//               on the link.
//   undefined - VC arbitration is re-decided every flit.
//
// Parameters:
//   FLIT_WIDTH    flit width in bits
//   VCHANNELS     number of virtual channels
//   INPUTS        router inputs competing for this output
//   BUFFER_DEPTH  per-VC FIFO depth (power of two, >= 2)
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_flit    [VCHANNELS][INPUTS][FLIT_WIDTH]  flit per VC per input
//   in_last    [VCHANNELS][INPUTS]              last flit of packet
//   in_valid   [VCHANNELS][INPUTS]              flit valid
//   in_ready   [VCHANNELS][INPUTS]              flit accepted on valid & ready
//   out_flit   [FLIT_WIDTH]                     link flit (0 when idle)
//   out_last   1                                link last flag (0 when idle)
//   out_valid  [VCHANNELS]                      one-hot VC of out_flit
//   out_ready  [VCHANNELS]                      downstream per-VC ready
// -----------------------------------------------------------------------------
module noc_router_output
  import noc_pkg::*;
#(
  parameter int FLIT_WIDTH   = 32,
  parameter int VCHANNELS    = 1,
  parameter int INPUTS       = 1,
  parameter int BUFFER_DEPTH = 4
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [VCHANNELS-1:0][INPUTS-1:0][FLIT_WIDTH-1:0] in_flit,
  input  logic [VCHANNELS-1:0][INPUTS-1:0]               in_last,
  input  logic [VCHANNELS-1:0][INPUTS-1:0]               in_valid,
  output logic [VCHANNELS-1:0][INPUTS-1:0]               in_ready,
  output logic [FLIT_WIDTH-1:0]                          out_flit,
  output logic                                           out_last,
  output logic [VCHANNELS-1:0]                           out_valid,
  input  logic [VCHANNELS-1:0]                           out_ready
);

  localparam int IW = idx_w(INPUTS);
  localparam int VW = idx_w(VCHANNELS);
  localparam int AW = idx_w(BUFFER_DEPTH);
  localparam int CW = $clog2(BUFFER_DEPTH) + 1;

  // FIFO heads and emptiness, gathered from the per-VC blocks.
  logic [VCHANNELS-1:0][FLIT_WIDTH:0] head;
  logic [VCHANNELS-1:0]               fifo_empty;

  // VC chosen for the link this cycle (one-hot) and its index.
  logic [VCHANNELS-1:0] vc_pick;
  logic [VW-1:0]        vc_win;

  // ---------------------------------------------------------------------------
  // Per-VC input arbitration and buffering
  // ---------------------------------------------------------------------------
  for (genvar v = 0; v < VCHANNELS; v++) begin : g_vc

    arb_state_e        state;
    logic [IW-1:0]     owner;
    logic [IW-1:0]     rr_ptr;

    logic [INPUTS-1:0] arb_grant;
    logic [IW-1:0]     arb_idx;
    logic [INPUTS-1:0] sel;
    logic [IW-1:0]     win_idx;
    logic              win_last;

    logic [FLIT_WIDTH:0] mem [BUFFER_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic                full;
    logic                wr_en;
    logic                rd_en;

    noc_router_arb_rr #(
      .N (INPUTS)
    ) u_in_arb (
      .req       (in_valid[v]),
      .ptr       (rr_ptr),
      .grant     (arb_grant),
      .grant_idx (arb_idx)
    );

    // While locked the owner keeps the grant even through its idle cycles,
    // so other inputs cannot slip a flit into the middle of its packet.
    always_comb begin
      if (state == LOCKED) begin
        sel     = INPUTS'(1) << owner;
        win_idx = owner;
      end else begin
        sel     = arb_grant;
        win_idx = arb_idx;
      end
    end

    assign full  = (count == CW'(BUFFER_DEPTH));
    assign rd_en = vc_pick[v];

    // A full FIFO can still take a flit when its head leaves this same cycle.
    assign in_ready[v] = rst ? '0 : (sel & {INPUTS{!full || rd_en}});

    assign wr_en    = |(in_valid[v] & in_ready[v]);
    assign win_last = in_last[v][win_idx];

    assign fifo_empty[v] = (count == '0);
    assign head[v]       = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every register in
    // this block samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
      if (rst) begin
        state  <= IDLE;
        owner  <= '0;
        rr_ptr <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_en) begin
          if (win_last) begin
            state  <= IDLE;
            rr_ptr <= IW'(wrap_inc(int'(win_idx), INPUTS));
          end else begin
            state <= LOCKED;
            owner <= win_idx;
          end
          // Depth is a power of two, so natural overflow is the modulo wrap.
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        case ({wr_en, rd_en})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

    // NOTE: the storage array has no reset; clearing count and pointers is
    // enough to make stale entries unreachable, and keeps it a plain RAM.
    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= {win_last, in_flit[v][win_idx]};
    end

  end : g_vc

  // ---------------------------------------------------------------------------
  // VC arbitration onto the link
  // ---------------------------------------------------------------------------
  logic [VCHANNELS-1:0] eligible;
  logic [VCHANNELS-1:0] vc_grant;
  logic [VW-1:0]        vc_idx;
  logic [VW-1:0]        vc_ptr;

  assign eligible = ~fifo_empty & out_ready;

  noc_router_arb_rr #(
    .N (VCHANNELS)
  ) u_vc_arb (
    .req       (eligible),
    .ptr       (vc_ptr),
    .grant     (vc_grant),
    .grant_idx (vc_idx)
  );

`ifdef NOC_ROUTER_OUTPUT_VCLOCK_EN
  logic          vc_locked;
  logic [VW-1:0] vc_owner;

  // A locked VC that is momentarily not eligible stalls the link rather than
  // letting another VC's flits interleave with its packet.
  always_comb begin
    if (rst) begin
      vc_pick = '0;
      vc_win  = '0;
    end else if (vc_locked) begin
      vc_pick = eligible & (VCHANNELS'(1) << vc_owner);
      vc_win  = vc_owner;
    end else begin
      vc_pick = vc_grant;
      vc_win  = vc_idx;
    end
  end
`else
  always_comb begin
    vc_pick = rst ? '0 : vc_grant;
    vc_win  = vc_idx;
  end
`endif

  assign out_valid = vc_pick;

  // Idle link drives zeros rather than whatever sits at a FIFO head.
  always_comb begin
    {out_last, out_flit} = '0;
    if (|vc_pick) {out_last, out_flit} = head[vc_win];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vc_ptr    <= '0;
`ifdef NOC_ROUTER_OUTPUT_VCLOCK_EN
      vc_locked <= 1'b0;
      vc_owner  <= '0;
`endif
    end else if (|vc_pick) begin
      vc_ptr    <= VW'(wrap_inc(int'(vc_win), VCHANNELS));
`ifdef NOC_ROUTER_OUTPUT_VCLOCK_EN
      vc_locked <= !out_last;
      vc_owner  <= vc_win;
`endif
    end
  end

endmodule : noc_router_output

// File: tb/tb_noc_router_output.sv
// -----------------------------------------------------------------------------
// tb_noc_router_output
// Self-checking bench for noc_router_output (FLIT_WIDTH=16, VCHANNELS=2,
// INPUTS=2, BUFFER_DEPTH=4). Stimulus pushes expected link flits into a
// scoreboard queue; an independent monitor pops and compares whenever
// out_valid is high. Expected orders are hand-derived from the arbitration
// rules; the VC interleave test follows NOC_ROUTER_OUTPUT_VCLOCK_EN.
// -----------------------------------------------------------------------------
module tb_noc_router_output;

  localparam int FW = 16;
  localparam int NV = 2;
  localparam int NI = 2;
  localparam int BD = 4;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [NV-1:0][NI-1:0][FW-1:0] in_flit;
  logic [NV-1:0][NI-1:0]         in_last;
  logic [NV-1:0][NI-1:0]         in_valid;
  logic [NV-1:0][NI-1:0]         in_ready;
  logic [FW-1:0]                 out_flit;
  logic                          out_last;
  logic [NV-1:0]                 out_valid;
  logic [NV-1:0]                 out_ready;

  noc_router_output #(
    .FLIT_WIDTH   (FW),
    .VCHANNELS    (NV),
    .INPUTS       (NI),
    .BUFFER_DEPTH (BD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in_flit),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    int          vc;
    logic        last;
    logic [FW-1:0] flit;
  } exp_t;

  exp_t sb[$];

  task automatic expect_flit(input int vc, input logic last, input logic [FW-1:0] flit);
    exp_t e;
    e.vc   = vc;
    e.last = last;
    e.flit = flit;
    sb.push_back(e);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    int   act_vc;
    forever begin
      @(negedge clk);
      if (out_valid != '0) begin
        check("out_valid_onehot", 32'($onehot(out_valid)), 32'd1);
        act_vc = out_valid[1] ? 1 : 0;
        if (sb.size() == 0) begin
          check("unexpected_flit", {15'd0, out_last, out_flit}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("out_vc",   32'(act_vc),   32'(e.vc));
          check("out_flit", 32'(out_flit), 32'(e.flit));
          check("out_last", 32'(out_last), 32'(e.last));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // VC0 stream driver: each input plays its own list of flits, honouring
  // in_ready. Also counts cycles where input 1 was ready while input 0 still
  // had flits left (used for the packet-lock test).
  // ---------------------------------------------------------------------------
  logic [FW-1:0] s_flit [2][8];
  logic          s_last [2][8];
  int            s_cnt  [2];

  task automatic run_vc0(input int budget, input bit watch_hold, output int viol, output bit done);
    int         idx [2];
    int         c;
    logic [1:0] acc;
    idx[0] = 0;
    idx[1] = 0;
    viol   = 0;
    done   = 1'b0;
    c      = 0;
    while (!done && c < budget) begin
      for (int i = 0; i < 2; i++) begin
        if (idx[i] < s_cnt[i]) begin
          in_valid[0][i] = 1'b1;
          in_flit[0][i]  = s_flit[i][idx[i]];
          in_last[0][i]  = s_last[i][idx[i]];
        end else begin
          in_valid[0][i] = 1'b0;
          in_flit[0][i]  = '0;
          in_last[0][i]  = 1'b0;
        end
      end
      if (idx[0] >= s_cnt[0] && idx[1] >= s_cnt[1]) begin
        done = 1'b1;
      end else begin
        @(negedge clk);
        acc = in_valid[0] & in_ready[0];
        if (watch_hold && idx[0] < s_cnt[0] && in_ready[0][1]) viol++;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) if (acc[i]) idx[i]++;
        c++;
      end
    end
    in_valid = '0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int viol;
    bit done;

    rst       = 1'b1;
    in_flit   = '0;
    in_last   = '0;
    in_valid  = '1;
    out_ready = '1;

    // Reset state: outputs forced quiet even with every input valid.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_flit",  32'(out_flit),  32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    @(posedge clk);
    #1;
    in_valid = '0;
    rst      = 1'b0;

    // Packet lock: A on input 0 wins (pointer 0), B waits until A2 is taken.
    s_cnt[0] = 3;
    s_cnt[1] = 3;
    for (int k = 0; k < 3; k++) begin
      s_flit[0][k] = 16'hA000 + 16'(k);
      s_flit[1][k] = 16'hB000 + 16'(k);
      s_last[0][k] = (k == 2);
      s_last[1][k] = (k == 2);
    end
    for (int k = 0; k < 3; k++) expect_flit(0, k == 2, 16'hA000 + 16'(k));
    for (int k = 0; k < 3; k++) expect_flit(0, k == 2, 16'hB000 + 16'(k));
    run_vc0(40, 1'b1, viol, done);
    check("lock_stream_done", 32'(done), 32'd1);
    check("lock_in1_held",    32'(viol), 32'd0);
    wait_drain(40);

    // Rotation: pointer is 0 after B. C0 (1-flit, input 0) goes first; with
    // both inputs still valid the next grant must be input 1 (E0), then D0.
    s_cnt[0] = 2;
    s_cnt[1] = 1;
    s_flit[0][0] = 16'hC000; s_last[0][0] = 1'b1;
    s_flit[0][1] = 16'hD000; s_last[0][1] = 1'b1;
    s_flit[1][0] = 16'hE000; s_last[1][0] = 1'b1;
    expect_flit(0, 1'b1, 16'hC000);
    expect_flit(0, 1'b1, 16'hE000);
    expect_flit(0, 1'b1, 16'hD000);
    run_vc0(40, 1'b0, viol, done);
    check("rot_stream_done", 32'(done), 32'd1);
    wait_drain(40);

    // FIFO full: four flits fill VC0 with the link stalled.
    out_ready = '0;
    for (int k = 0; k < 5; k++) expect_flit(0, k == 4, 16'hF000 + 16'(k));
    for (int k = 0; k < 4; k++) begin
      in_valid[0][0] = 1'b1;
      in_flit[0][0]  = 16'hF000 + 16'(k);
      in_last[0][0]  = 1'b0;
      @(negedge clk);
      check("fill_ready", 32'(in_ready[0][0]), 32'd1);
      @(posedge clk);
      #1;
    end
    in_flit[0][0] = 16'hF004;
    in_last[0][0] = 1'b1;
    @(negedge clk);
    check("full_ready", 32'(in_ready[0][0]), 32'd0);
    @(posedge clk);
    #1;
    // Read and write together on a full FIFO.
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("full_rw_ready", 32'(in_ready[0][0]), 32'd1);
    @(posedge clk);
    #1;
    // Occupancy must still be 4: a further flit is refused.
    out_ready      = '0;
    in_flit[0][0]  = 16'hDEAD;
    in_last[0][0]  = 1'b1;
    @(negedge clk);
    check("still_full", 32'(in_ready[0][0]), 32'd0);
    in_valid = '0;
    @(posedge clk);
    #1;
    out_ready = '1;
    wait_drain(40);

    // VC interleave from a clean reset: both VCs hold a 2-flit packet.
    do_reset();
    out_ready = '0;
    for (int k = 0; k < 2; k++) begin
      in_valid[0][0] = 1'b1; in_flit[0][0] = 16'h6000 + 16'(k); in_last[0][0] = (k == 1);
      in_valid[1][0] = 1'b1; in_flit[1][0] = 16'h7000 + 16'(k); in_last[1][0] = (k == 1);
      @(negedge clk);
      check("vc_fill_ready", 32'({in_ready[1][0], in_ready[0][0]}), 32'd3);
      @(posedge clk);
      #1;
    end
    in_valid = '0;
`ifdef NOC_ROUTER_OUTPUT_VCLOCK_EN
    expect_flit(0, 1'b0, 16'h6000);
    expect_flit(0, 1'b1, 16'h6001);
    expect_flit(1, 1'b0, 16'h7000);
    expect_flit(1, 1'b1, 16'h7001);
`else
    expect_flit(0, 1'b0, 16'h6000);
    expect_flit(1, 1'b0, 16'h7000);
    expect_flit(0, 1'b1, 16'h6001);
    expect_flit(1, 1'b1, 16'h7001);
`endif
    out_ready = '1;
    wait_drain(20);

    // Reset mid-packet: two of four flits buffered and VC0 locked to input 0.
    out_ready = '0;
    for (int k = 0; k < 2; k++) begin
      in_valid[0][0] = 1'b1;
      in_flit[0][0]  = 16'h9000 + 16'(k);
      in_last[0][0]  = 1'b0;
      @(posedge clk);
      #1;
    end
    in_flit[0][0] = 16'h9002;
    rst           = 1'b1;
    @(negedge clk);
    check("midrst_in_ready",  32'(in_ready),  32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_flit",  32'(out_flit),  32'd0);
    @(posedge clk);
    #1;
    rst            = 1'b0;
    in_valid       = '0;
    in_valid[0][1] = 1'b1;
    in_flit[0][1]  = 16'h5000;
    in_last[0][1]  = 1'b1;
    out_ready      = '1;
    expect_flit(0, 1'b1, 16'h5000);
    @(negedge clk);
    check("postrst_empty",  32'(out_valid),      32'd0);
    check("postrst_grant1", 32'(in_ready[0][1]), 32'd1);
    check("postrst_in0",    32'(in_ready[0][0]), 32'd0);
    @(posedge clk);
    #1;
    in_valid = '0;
    wait_drain(20);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (bad=%0d)", bad);
    $fatal(1, "timeout");
  end

endmodule : tb_noc_router_output
